// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer.
// Holds the sequencer state encoding, the fixed reconfig-bus register
// addresses and the bus/entry width constants used by the top level and
// by the staging FIFO.
package pll_cfg_pkg;

    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 32;
    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam int CNT_W   = 20;

    // Waitrequest-mode register and the register that kicks the reconfig.
    localparam logic [ADDR_W-1:0] MODE_ADDR  = 6'h00;
    localparam logic [ADDR_W-1:0] START_ADDR = 6'h02;

    typedef enum logic [2:0] {
        IDLE,
        MODE,
        WRITE,
        START,
        WAIT_UNLOCK,
        WAIT_LOCK,
        DONE
    } state_e;

endpackage

// File: rtl/pll_cfg_fifo.sv
// Staging FIFO for reconfiguration entries {address, data}.
// Show-ahead read: rdata_o always presents the oldest entry, pop_i retires it.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset (pointers only)
//   push_i, wdata_i   write an entry (ignored when full)
//   pop_i             retire the head entry (ignored when empty)
//   rdata_o           head entry
//   full_o, empty_o   occupancy flags
module pll_cfg_fifo
    import pll_cfg_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PTR_ONE;
            if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/pll_cfg_sequencer.sv
// PLL reconfiguration sequencer.
// Stages {address, data} entries while idle, then on start writes the
// waitrequest-mode register, every staged entry in order, and the start
// register over the reconfig management bus, and finally waits for the PLL
// to drop and regain lock, each wait bounded by TIMEOUT refclk cycles.
// Ports:
//   refclk, rst_n                    clock, asynchronous active-low reset
//   cfg_valid/cfg_ready/cfg_addr/cfg_data   staging handshake
//   start, busy, done, error         sequence control and status
//   mgmt_address/write/writedata/waitrequest   reconfig management bus
//   pll_locked                       asynchronous lock indication
module pll_cfg_sequencer
    import pll_cfg_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1048576
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] mgmt_address,
    output logic              mgmt_write,
    output logic [DATA_W-1:0] mgmt_writedata,
    input  logic              mgmt_waitrequest,
    input  logic              pll_locked
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                lock_s1_q, lock_s2_q;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                mwrite_q, mwrite_d;
    logic [ADDR_W-1:0]   maddr_q, maddr_d;
    logic [DATA_W-1:0]   mdata_q, mdata_d;

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [ENTRY_W-1:0]  fifo_head;
    logic                wr_done;

    assign cfg_ready = (state_q == IDLE) && !fifo_full;
    assign fifo_push = cfg_valid && cfg_ready;
    assign wr_done   = mwrite_q && !mgmt_waitrequest;

    pll_cfg_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i   (refclk),
        .rst_ni  (rst_n),
        .push_i  (fifo_push),
        .wdata_i ({cfg_addr, cfg_data}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lock_s1_q <= 1'b0;
            lock_s2_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            mwrite_q  <= 1'b0;
            maddr_q   <= '0;
            mdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lock_s1_q <= pll_locked;
            lock_s2_q <= lock_s1_q;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            mwrite_q  <= mwrite_d;
            maddr_q   <= maddr_d;
            mdata_q   <= mdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        error_d  = error_q;
        mwrite_d = mwrite_q;
        maddr_d  = maddr_q;
        mdata_d  = mdata_q;
        fifo_pop = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (fifo_empty) begin
                        error_d = 1'b1;
                    end else begin
                        error_d  = 1'b0;
                        busy_d   = 1'b1;
                        mwrite_d = 1'b1;
                        maddr_d  = MODE_ADDR;
                        mdata_d  = '0;
                        state_d  = MODE;
                    end
                end
            end
            // The head entry is popped as it is loaded onto the bus, so
            // in WRITE an empty FIFO means the entry on the bus is the last.
            MODE: begin
                if (wr_done) begin
                    fifo_pop = 1'b1;
                    maddr_d  = fifo_head[ENTRY_W-1:DATA_W];
                    mdata_d  = fifo_head[DATA_W-1:0];
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                if (wr_done) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        maddr_d  = fifo_head[ENTRY_W-1:DATA_W];
                        mdata_d  = fifo_head[DATA_W-1:0];
                    end else begin
                        maddr_d  = START_ADDR;
                        mdata_d  = '0;
                        state_d  = START;
                    end
                end
            end
            START: begin
                if (wr_done) begin
                    mwrite_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = WAIT_UNLOCK;
                end
            end
            WAIT_UNLOCK: begin
                if (!lock_s2_q) begin
                    cnt_d   = '0;
                    state_d = WAIT_LOCK;
                end else if (cnt_q == CNT_LAST) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_LOCK: begin
                if (lock_s2_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign mgmt_write     = mwrite_q;
    assign mgmt_address   = maddr_q;
    assign mgmt_writedata = mdata_q;

endmodule

// File: tb/tb_pll_cfg_sequencer.sv
// Testbench for pll_cfg_sequencer: directed sequences, a vector table for
// FIFO fill / start-while-busy, and randomized runs against a queue model
// of the expected bus writes and outcome.
module tb_pll_cfg_sequencer;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;

    logic        refclk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [5:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        start;
    logic        busy;
    logic        done;
    logic        error;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest;
    logic        pll_locked;

    pll_cfg_sequencer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .refclk           (refclk),
        .rst_n            (rst_n),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_addr         (cfg_addr),
        .cfg_data         (cfg_data),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .mgmt_address     (mgmt_address),
        .mgmt_write       (mgmt_write),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_waitrequest (mgmt_waitrequest),
        .pll_locked       (pll_locked)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        logic        vld;
        logic [5:0]  a;
        logic [31:0] d;
        logic        st;
        logic        ex_rdy;
        logic        ex_busy;
        logic        ex_err;
    } vec_t;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          n_done = 0;
    bit          rand_wr = 1'b0;
    logic [37:0] wr_q  [$];
    logic [37:0] exp_q [$];
    vec_t        tbl   [11];
    logic [38:0] exp_seq [4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge refclk);
        #1;
        if (rand_wr) mgmt_waitrequest = ($urandom_range(0, 2) == 0);
    endtask

    task automatic push(input logic [5:0] a, input logic [31:0] d);
        chk("push_ready", cfg_ready, 1'b1);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        cyc();
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic cmp_q(input string nm);
        chk({nm, "_len"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
            chk(nm, wr_q[i], exp_q[i]);
    endtask

    // Waits for nwr completed writes, then plays a lock scenario:
    // plan 0 drop then raise (success), 1 never drop, 2 drop and stay low.
    task automatic tail(input int plan, input int nwr);
        int guard;
        int done0;
        bit ok;
        guard = 0;
        while (wr_q.size() < nwr && guard < 400) begin
            cyc();
            guard++;
        end
        chk("wr_count", wr_q.size(), nwr);
        done0 = n_done;
        if (plan != 1) begin
            pll_locked = 1'b0;
            repeat ($urandom_range(3, 8)) cyc();
            if (plan == 0) pll_locked = 1'b1;
        end
        ok    = !busy;
        guard = 0;
        while (!ok && guard < 60) begin
            cyc();
            guard++;
            ok = !busy;
        end
        chk("busy_drop", ok, 1'b1);
        cyc();
        cyc();
        chk("done_pulses", n_done - done0, (plan == 0) ? 1 : 0);
        chk("error_flag", error, (plan != 0));
        chk("fifo_empty", dut.u_fifo.empty_o, 1'b1);
        pll_locked = 1'b1;
        repeat (3) cyc();
    endtask

    // Bus monitor: records completed writes, checks stall stability and
    // that the done pulse never coincides with busy.
    initial begin : monitor
        logic        prev_stall;
        logic [37:0] prev_ad;
        prev_stall = 1'b0;
        prev_ad    = '0;
        forever begin
            @(negedge refclk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    chk("stall_hold", {mgmt_write, mgmt_address, mgmt_writedata}, {1'b1, prev_ad});
                prev_stall = mgmt_write && mgmt_waitrequest;
                prev_ad    = {mgmt_address, mgmt_writedata};
                if (mgmt_write && !mgmt_waitrequest)
                    wr_q.push_back({mgmt_address, mgmt_writedata});
                if (done) begin
                    n_done++;
                    chk("done_busy_low", busy, 1'b0);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          n;
        int          plan;
        int          guard;
        logic [5:0]  a;
        logic [31:0] d;

        rst_n            = 1'b0;
        cfg_valid        = 1'b0;
        cfg_addr         = '0;
        cfg_data         = '0;
        start            = 1'b0;
        mgmt_waitrequest = 1'b0;
        pll_locked       = 1'b1;

        // Reset state, including cfg_ready high while held in reset.
        #2;
        chk("reset_outs", {busy, done, error, mgmt_write, mgmt_address, mgmt_writedata, cfg_ready},
            {3'b000, 1'b0, 6'h00, 32'h0, 1'b1});
        cyc();
        cyc();
        rst_n = 1'b1;
        repeat (3) cyc();

        // Nominal sequence, back-to-back writes.
        wr_q.delete();
        push(6'h04, 32'h0000_0808);
        push(6'h05, 32'h0000_0202);
        pulse_start();
        exp_seq[0] = {1'b1, 6'h00, 32'h0};
        exp_seq[1] = {1'b1, 6'h04, 32'h0000_0808};
        exp_seq[2] = {1'b1, 6'h05, 32'h0000_0202};
        exp_seq[3] = {1'b1, 6'h02, 32'h0};
        chk("busy_after_start", busy, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("seq%0d", i), {mgmt_write, mgmt_address, mgmt_writedata}, exp_seq[i]);
            cyc();
        end
        chk("unlock_no_write", mgmt_write, 1'b0);
        tail(0, 4);
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(exp_seq[i][37:0]);
        cmp_q("nominal_writes");

        // Waitrequest stall on the second bus write.
        wr_q.delete();
        push(6'h04, 32'h0000_0808);
        push(6'h05, 32'h0000_0202);
        pulse_start();
        cyc();
        mgmt_waitrequest = 1'b1;
        repeat (5) begin
            cyc();
            chk("stall_value", {mgmt_write, mgmt_address, mgmt_writedata}, {1'b1, 6'h04, 32'h0000_0808});
        end
        mgmt_waitrequest = 1'b0;
        cyc();
        chk("after_release", {mgmt_write, mgmt_address, mgmt_writedata}, {1'b1, 6'h05, 32'h0000_0202});
        tail(0, 4);
        cmp_q("stall_writes");

        // Start with nothing staged.
        pulse_start();
        chk("empty_start", {error, mgmt_write, busy}, 3'b100);
        repeat (3) begin
            cyc();
            chk("empty_start_quiet", {mgmt_write, busy}, 2'b00);
        end

        // Lock never drops: timeout exactly 16 cycles after WAIT_UNLOCK entry.
        wr_q.delete();
        push(6'h10, 32'h0000_1234);
        pulse_start();
        guard = 0;
        while (!(mgmt_write && mgmt_address == 6'h02) && guard < 20) begin
            cyc();
            guard++;
        end
        chk("start_write_seen", {mgmt_write, mgmt_address}, {1'b1, 6'h02});
        cyc();
        repeat (15) cyc();
        chk("timeout_pending", {busy, error}, 2'b10);
        cyc();
        chk("timeout_hit", {busy, error}, 2'b01);
        chk("timeout_fifo_empty", dut.u_fifo.empty_o, 1'b1);

        // Vector table: fill to DEPTH, ninth entry refused, start while busy ignored.
        for (int i = 0; i < 11; i++) begin
            tbl[i].vld     = (i <= 8);
            tbl[i].a       = 6'(8 + i);
            tbl[i].d       = 32'hA000_0000 + 32'(i);
            tbl[i].st      = (i >= 9);
            tbl[i].ex_rdy  = (i < 8);
            tbl[i].ex_busy = (i >= 9);
            tbl[i].ex_err  = (i < 9);
        end
        wr_q.delete();
        exp_q.delete();
        exp_q.push_back({6'h00, 32'h0});
        mgmt_waitrequest = 1'b1;
        for (int i = 0; i < 11; i++) begin
            cfg_valid = tbl[i].vld;
            cfg_addr  = tbl[i].a;
            cfg_data  = tbl[i].d;
            start     = tbl[i].st;
            chk($sformatf("tbl%0d_ready", i), cfg_ready, tbl[i].ex_rdy);
            if (tbl[i].vld && tbl[i].ex_rdy) exp_q.push_back({tbl[i].a, tbl[i].d});
            cyc();
            chk($sformatf("tbl%0d_busy_err", i), {busy, error}, {tbl[i].ex_busy, tbl[i].ex_err});
        end
        cfg_valid        = 1'b0;
        start            = 1'b0;
        mgmt_waitrequest = 1'b0;
        exp_q.push_back({6'h02, 32'h0});
        tail(0, exp_q.size());
        cmp_q("fill_writes");

        // Reset in the middle of the entry writes.
        push(6'h11, 32'h1);
        push(6'h12, 32'h2);
        push(6'h13, 32'h3);
        pulse_start();
        cyc();
        chk("in_write", {mgmt_write, mgmt_address}, {1'b1, 6'h11});
        rst_n = 1'b0;
        #1;
        chk("reset_mid_write", {mgmt_write, busy, cfg_ready}, 3'b001);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("after_reset", {busy, cfg_ready, dut.u_fifo.empty_o}, 3'b011);
        pulse_start();
        chk("no_entries_survive", {error, busy}, 2'b10);
        repeat (3) cyc();

        // Randomized runs against the queue model.
        rand_wr = 1'b1;
        for (int it = 0; it < 25; it++) begin
            wr_q.delete();
            exp_q.delete();
            exp_q.push_back({6'h00, 32'h0});
            n = $urandom_range(1, DEPTH);
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 1) == 1) cyc();
                a = 6'($urandom_range(0, 63));
                d = $urandom;
                push(a, d);
                exp_q.push_back({a, d});
            end
            exp_q.push_back({6'h02, 32'h0});
            pulse_start();
            plan = $urandom_range(0, 2);
            tail(plan, exp_q.size());
            cmp_q("rand_writes");
        end
        rand_wr          = 1'b0;
        mgmt_waitrequest = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
